// File: rtl/ss_serializer_if.sv
// Load-side handshake and serial output bundle of ss_serializer.
// The serializer connects through the slave modport and the word producer through master.
interface ss_serializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             enable;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;
  logic [CNT_W-1:0] word_count;
  logic             idle;

  modport master (
    output load_data, load_valid, enable,
    input  load_ready, ser_out, ser_valid, word_done, word_count, idle
  );

  modport slave (
    input  load_data, load_valid, enable,
    output load_ready, ser_out, ser_valid, word_done, word_count, idle
  );
endinterface

// File: rtl/ss_serializer.sv
// Parallel-to-serial bit source feeding the sequence detector.
// A one-word hold register lets the next word load while the current one shifts.
module ss_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic           clock,
  input  logic           reset,
  ss_serializer_if.slave bus
);
  localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
  logic             idle_q, idle_d;
  logic             accept_s;
  logic             take_hold_s;
  logic             last_bit_s;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // No same-edge pass-through: a hold emptied at an edge only frees the slot after it.
  assign bus.load_ready = !reset && !hold_full_q;
  assign accept_s       = bus.load_valid && bus.load_ready;

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      bit_cnt_q    <= '0;
      word_count_q <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      word_done_q  <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      bit_cnt_q    <= bit_cnt_d;
      word_count_q <= word_count_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      word_done_q  <= word_done_d;
      idle_q       <= idle_d;
    end
  end

  // Next-state logic: hold-to-shifter transfers, bit stepping and word completion.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    word_count_d = word_count_q;
    word_done_d  = 1'b0;
    take_hold_s  = 1'b0;
    last_bit_s   = (bit_cnt_q == LAST_BIT);
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          take_hold_s = 1'b1;
          shift_d     = hold_q;
          bit_cnt_d   = '0;
          state_d     = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.enable && !last_bit_s) begin
          shift_d   = advance(shift_q);
          bit_cnt_d = bit_cnt_q + BW'(1);
        end else if (bus.enable) begin
          word_done_d  = 1'b1;
          word_count_d = word_count_q + CNT_W'(1);
          if (hold_full_q) begin
            take_hold_s = 1'b1;
            shift_d     = hold_q;
            bit_cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    hold_full_d = accept_s ? 1'b1 : (take_hold_s ? 1'b0 : hold_full_q);
    hold_d      = accept_s ? bus.load_data : hold_q;
  end

  // Output logic: outputs are derived from next state so they register alongside it.
  always_comb begin
    ser_valid_d = (state_d == ST_SHIFT);
    ser_out_d   = ser_valid_d ? first_bit(shift_d) : 1'b0;
    idle_d      = (state_d == ST_IDLE) && !hold_full_d;
  end

  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.word_done  = word_done_q;
  assign bus.word_count = word_count_q;
  assign bus.idle       = idle_q;
endmodule
